rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/rst_auto_timer.sv | 31 +++
 rtl/rst_sequencer.sv | 137 +++++++++++++
 tb/tb_rst_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared state encoding, domain count and cause-bit layout for the reset sequencer.
package rst_seq_pkg;
    localparam int NDOM       = 4;
    localparam int STAGE_W    = $clog2(NDOM);
    localparam int CAUSE_W    = NDOM + 1;
    localparam int CAUSE_REQ0 = 0;
    localparam int CAUSE_AUTO = 4;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } seq_state_e;

    // Down-counters expire at zero, so an N-cycle interval loads N-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cyc);
        return CNT_W'(cyc - 1);
    endfunction
endpackage

// File: rtl/rst_auto_timer.sv
// Free-running period timer that emits a one-cycle auto_tick every AUTO_PERIOD cycles while enabled.
module rst_auto_timer #(
    parameter logic [31:0] AUTO_PERIOD = 32'd267_777_777
) (
    input  logic clk_sys,
    input  logic rst_in,
    input  logic auto_en,
    output logic auto_tick
);
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        at_end;

    assign at_end    = (cnt_q == AUTO_PERIOD - 32'd1);
    assign auto_tick = auto_en && at_end;

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (!auto_en || at_end) begin
            cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rst_sequencer.sv
// Multi-domain reset sequencer: holds all domains in reset, then releases them in order 0..3.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned GAP_CYC     = 8,
    parameter logic [31:0] AUTO_PERIOD = 32'd267_777_777
) (
    input  logic               clk_sys,
    input  logic               rst_in,
    input  logic [NDOM-1:0]    req,
    input  logic               auto_en,
    output logic [NDOM-1:0]    rst_dom,
    output logic               busy,
    output logic               done,
    output logic [CAUSE_W-1:0] cause
);
    localparam logic [CNT_W-1:0] HOLD_LOAD = cnt_load(HOLD_CYC);
    localparam logic [CNT_W-1:0] GAP_LOAD  = cnt_load(GAP_CYC);

    logic auto_tick;

    rst_auto_timer #(
        .AUTO_PERIOD(AUTO_PERIOD)
    ) u_auto_timer (
        .clk_sys  (clk_sys),
        .rst_in   (rst_in),
        .auto_en  (auto_en),
        .auto_tick(auto_tick)
    );

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [NDOM-1:0]    dom_q, dom_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [CAUSE_W-1:0] new_cause;
    logic               trigger;

    always_comb begin
        new_cause                     = '0;
        new_cause[CAUSE_REQ0 +: NDOM] = req;
        new_cause[CAUSE_AUTO]         = auto_tick;
        trigger                       = |new_cause;

        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        stage_d = stage_q;
        dom_d   = dom_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cause_d = cause_q;

        if (state_q == ST_IDLE) begin
            if (trigger) begin
                state_d = ST_ASSERT;
                hold_d  = HOLD_LOAD;
                stage_d = '0;
                dom_d   = '1;
                busy_d  = 1'b1;
                cause_d = new_cause;
            end
        end else if (trigger) begin
            // Any new request while busy restarts the full hold/release timing.
            state_d = ST_ASSERT;
            hold_d  = HOLD_LOAD;
            stage_d = '0;
            dom_d   = '1;
            busy_d  = 1'b1;
            cause_d = cause_q | new_cause;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (hold_q == '0) begin
                        state_d  = ST_RELEASE;
                        stage_d  = '0;
                        gap_d    = GAP_LOAD;
                        dom_d[0] = 1'b0;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - 1'b1;
                    end else if (stage_q == STAGE_W'(NDOM - 1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        stage_d        = stage_q + 1'b1;
                        gap_d          = GAP_LOAD;
                        dom_d[stage_d] = 1'b0;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_ASSERT;
            hold_q  <= HOLD_LOAD;
            gap_q   <= '0;
            stage_q <= '0;
            dom_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            stage_q <= stage_d;
            dom_q   <= dom_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    assign rst_dom = dom_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cause   = cause_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: timestamp-based reference model, vector table, corner sequences, random run.
module tb_rst_sequencer;
    localparam int HOLD    = 4;
    localparam int GAP     = 2;
    localparam int PER     = 50;
    localparam int SEQ_LEN = HOLD + 4 * GAP;

    logic       clk_sys = 1'b0;
    logic       rst_in  = 1'b1;
    logic       auto_en = 1'b0;
    logic [3:0] req     = 4'h0;
    logic [3:0] rst_dom;
    logic       busy;
    logic       done;
    logic [4:0] cause;

    rst_sequencer #(
        .HOLD_CYC   (HOLD),
        .GAP_CYC    (GAP),
        .AUTO_PERIOD(32'd50)
    ) dut (
        .clk_sys(clk_sys),
        .rst_in (rst_in),
        .req    (req),
        .auto_en(auto_en),
        .rst_dom(rst_dom),
        .busy   (busy),
        .done   (done),
        .cause  (cause)
    );

    always #5 clk_sys = ~clk_sys;

    int n_assert = 0;
    int n_fail   = 0;
    int ecnt     = 0;
    int n_done   = 0;
    int n_starts = 0;
    logic busy_prev = 1'b0;

    // Reference model: a sequence is described only by the edge it (re)started on.
    bit         m_busy   = 1'b0;
    int         m_start  = 0;
    logic [4:0] m_cause  = 5'h0;
    int         m_en_len = 0;

    typedef struct {
        logic [3:0]  req;
        logic [10:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, ecnt, act, exp);
        end
    endtask

    function automatic void model_async_reset();
        m_busy   = 1'b1;
        m_start  = ecnt;
        m_cause  = 5'h0;
        m_en_len = 0;
    endfunction

    function automatic void model_edge();
        logic       tick;
        logic [4:0] nc;
        if (!rst_in) begin
            model_async_reset();
            return;
        end
        if (auto_en) m_en_len++;
        else         m_en_len = 0;
        tick = auto_en && (m_en_len % PER == 0);
        nc   = {tick, req};
        if (nc != 5'h0) begin
            m_cause = m_busy ? (m_cause | nc) : nc;
            m_busy  = 1'b1;
            m_start = ecnt;
        end else if (m_busy && (ecnt - m_start > SEQ_LEN)) begin
            m_busy = 1'b0;
        end
    endfunction

    function automatic logic [10:0] model_out();
        logic [3:0] dom;
        int         t;
        if (!m_busy) return {4'h0, 1'b0, 1'b0, m_cause};
        t = ecnt - m_start;
        for (int k = 0; k < 4; k++) dom[k] = (t < HOLD + k * GAP);
        return {dom, 1'b1, (t == SEQ_LEN), m_cause};
    endfunction

    function automatic logic [31:0] dut_out();
        return 32'({rst_dom, busy, done, cause});
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
        ecnt++;
        model_edge();
        check("model", dut_out(), 32'(model_out()));
        if (done) n_done++;
        if (busy && !busy_prev) n_starts++;
        busy_prev = busy;
    endtask

    function automatic void add(input logic [3:0] r, input logic [3:0] d, input logic b,
                                input logic dn, input logic [4:0] c);
        vec_t v;
        v.req = r;
        v.exp = {d, b, dn, c};
        vecs.push_back(v);
    endfunction

    initial begin
        // Power-on release, then a req[2] sequence from IDLE.
        repeat (3) add(4'h0, 4'hF, 1'b1, 1'b0, 5'h00);
        repeat (2) add(4'h0, 4'hE, 1'b1, 1'b0, 5'h00);
        repeat (2) add(4'h0, 4'hC, 1'b1, 1'b0, 5'h00);
        repeat (2) add(4'h0, 4'h8, 1'b1, 1'b0, 5'h00);
        repeat (2) add(4'h0, 4'h0, 1'b1, 1'b0, 5'h00);
        add(4'h0, 4'h0, 1'b1, 1'b1, 5'h00);
        repeat (2) add(4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
        add(4'h4, 4'hF, 1'b1, 1'b0, 5'h04);
        repeat (3) add(4'h0, 4'hF, 1'b1, 1'b0, 5'h04);
        repeat (2) add(4'h0, 4'hE, 1'b1, 1'b0, 5'h04);
        repeat (2) add(4'h0, 4'hC, 1'b1, 1'b0, 5'h04);
        repeat (2) add(4'h0, 4'h8, 1'b1, 1'b0, 5'h04);
        repeat (2) add(4'h0, 4'h0, 1'b1, 1'b0, 5'h04);
        add(4'h0, 4'h0, 1'b1, 1'b1, 5'h04);
        repeat (2) add(4'h0, 4'h0, 1'b0, 1'b0, 5'h04);

        #1 rst_in = 1'b0;
        #1 model_async_reset();
        check("reset_values", dut_out(), 32'({4'hF, 1'b1, 1'b0, 5'h00}));
        repeat (3) step();
        rst_in = 1'b1;

        foreach (vecs[i]) begin
            req = vecs[i].req;
            step();
            check($sformatf("vec%0d", i), dut_out(), 32'(vecs[i].exp));
            $display("vec %0d req=%b -> rst_dom=%b busy=%b done=%b cause=%b", i, vecs[i].req, rst_dom, busy, done, cause);
        end
        req = 4'h0;

        // Re-trigger from RELEASE after domains 0 and 1 are out of reset.
        req = 4'h4; step(); req = 4'h0;
        repeat (6) step();
        check("release_mid_dom", 32'(rst_dom), 32'h0000000C);
        req = 4'h2; step(); req = 4'h0;
        check("retrigger_dom", 32'(rst_dom), 32'h0000000F);
        check("retrigger_cause", 32'(cause), 32'h00000006);
        n_done = 0;
        repeat (13) step();
        check("retrigger_done_count", 32'(n_done), 32'd1);
        check("retrigger_idle", 32'(busy), 32'd0);
        $display("seq retrigger: done pulses=%0d cause=%b", n_done, cause);

        // Periodic auto requests, then disable.
        auto_en = 1'b1; n_done = 0; n_starts = 0;
        repeat (170) step();
        check("auto_starts", 32'(n_starts), 32'd3);
        check("auto_dones", 32'(n_done), 32'd3);
        check("auto_cause", 32'(cause), 32'h00000010);
        auto_en = 1'b0; n_starts = 0;
        repeat (120) step();
        check("auto_off_starts", 32'(n_starts), 32'd0);
        $display("seq auto: cause=%b busy=%b", cause, busy);

        // Requests coincident with an auto tick merge into one sequence.
        auto_en = 1'b1;
        repeat (49) step();
        req = 4'h9; step(); req = 4'h0; auto_en = 1'b0;
        check("coincident_cause", 32'(cause), 32'h00000019);
        n_done = 0; n_starts = 0;
        repeat (20) step();
        check("coincident_done_count", 32'(n_done), 32'd1);
        check("coincident_starts", 32'(n_starts), 32'd0);
        $display("seq coincident: cause=%b done pulses=%0d", cause, n_done);

        // Async reset in the middle of an ASSERT re-trigger.
        req = 4'h8; step(); req = 4'h0; step();
        req = 4'h1; step(); req = 4'h0; step();
        #2 rst_in = 1'b0;
        #1 model_async_reset();
        check("abort_values", dut_out(), 32'({4'hF, 1'b1, 1'b0, 5'h00}));
        n_done = 0;
        repeat (2) step();
        rst_in = 1'b1;
        repeat (12) step();
        check("abort_done_time", 32'(done), 32'd1);
        step();
        check("abort_done_count", 32'(n_done), 32'd1);
        check("abort_cause", 32'(cause), 32'h00000000);
        $display("seq abort: done pulses=%0d cause=%b", n_done, cause);

        // Random traffic against the model.
        for (int i = 0; i < 900; i++) begin
            req = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 249) == 0) begin
                #1 rst_in = 1'b0;
                #1 model_async_reset();
                check("rand_abort", dut_out(), 32'({4'hF, 1'b1, 1'b0, 5'h00}));
                step();
                rst_in = 1'b1;
            end
            step();
        end
        $display("seq random: %0d edges total", ecnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
